// File: rtl/cpu_configuration_pkg.sv
// Shared CPU configuration: default datapath width, architectural register count
// and the register-address type derived from them.
package cpu_configuration;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits. An issue marks the destination pending and a write
// retires it. Reads see the state after write-clear but before issue-set.
module regfile_scoreboard
    import cpu_configuration::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NWR   = 2,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NWR-1:0]          i_wr_valid,
    input  logic [NWR-1:0][AW-1:0]  i_wr_ad,
    input  logic                    i_iss_valid,
    input  logic [AW-1:0]           i_iss_ad,
    input  logic                    i_flush,
    input  logic [NRD-1:0][AW-1:0]  i_rd_ad,
    output logic [NRD-1:0]          o_rd_rdy
);

    localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_mid;

    function automatic logic in_range(input logic [AW-1:0] ad);
        return {1'b0, ad} < LIMIT;
    endfunction

    // Register 0 is never marked, so it always reads as ready.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int p = 0; p < NWR; p++) begin
            if (i_wr_valid[p] && in_range(i_wr_ad[p])) begin
                w_clr[i_wr_ad[p]] = 1'b1;
            end
        end
        if (i_iss_valid && in_range(i_iss_ad) && (i_iss_ad != '0)) begin
            w_set[i_iss_ad] = 1'b1;
        end
    end

    assign w_mid = r_pend & ~w_clr;

    always_comb begin
        o_rd_rdy = '1;
        for (int i = 0; i < NRD; i++) begin
            if (in_range(i_rd_ad[i])) begin
                o_rd_rdy[i] = ~w_mid[i_rd_ad[i]];
            end
        end
    end

    // Setting after clearing lets a same-cycle issue win over the retiring write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else if (i_flush) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_mid | w_set;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Multi-ported register file with write-to-read bypass, registered read outputs
// and a scoreboard reporting whether the read register has an outstanding producer.
module register_file_sb
    import cpu_configuration::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = 2,
    parameter  int NWR   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NWR-1:0]           w_valid,
    input  logic [NWR-1:0][AW-1:0]   w_ad,
    input  logic [NWR-1:0][XLEN-1:0] w_data,
    input  logic [NRD-1:0]           r_valid,
    input  logic [NRD-1:0][AW-1:0]   r_ad,
    output logic [NRD-1:0][XLEN-1:0] r_data,
    output logic [NRD-1:0]           r_ack,
    output logic [NRD-1:0]           r_rdy,
    input  logic                     iss_valid,
    input  logic [AW-1:0]            iss_ad,
    input  logic                     flush
);

    localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

    logic [XLEN-1:0]           r_regs [NREGS];
    logic [NRD-1:0][XLEN-1:0]  w_rd_val;
    logic [NRD-1:0]            w_sb_rdy;

    function automatic logic in_range(input logic [AW-1:0] ad);
        return {1'b0, ad} < LIMIT;
    endfunction

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_wr_valid  (w_valid),
        .i_wr_ad     (w_ad),
        .i_iss_valid (iss_valid),
        .i_iss_ad    (iss_ad),
        .i_flush     (flush),
        .i_rd_ad     (r_ad),
        .o_rd_rdy    (w_sb_rdy)
    );

    // Later ports are assigned last, so the highest-indexed port wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NREGS; n++) begin
                r_regs[n] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (w_valid[p] && in_range(w_ad[p]) && (w_ad[p] != '0)) begin
                    r_regs[w_ad[p]] <= w_data[p];
                end
            end
        end
    end

    // Bypass uses the same port priority as the storage update.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NRD; i++) begin
            if (in_range(r_ad[i]) && (r_ad[i] != '0)) begin
                w_rd_val[i] = r_regs[r_ad[i]];
                for (int p = 0; p < NWR; p++) begin
                    if (w_valid[p] && (w_ad[p] == r_ad[i])) begin
                        w_rd_val[i] = w_data[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_rdy  <= '0;
            r_ack  <= '0;
        end else begin
            r_ack <= r_valid;
            for (int i = 0; i < NRD; i++) begin
                if (r_valid[i]) begin
                    r_data[i] <= w_rd_val[i];
                    r_rdy[i]  <= w_sb_rdy[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed scenarios with literal
// expectations plus randomized traffic checked against an array-based model.
module tb_register_file_sb;
    import cpu_configuration::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = $clog2(NREGS);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NWR-1:0]           w_valid;
    logic [NWR-1:0][AW-1:0]   w_ad;
    logic [NWR-1:0][XLEN-1:0] w_data;
    logic [NRD-1:0]           r_valid;
    logic [NRD-1:0][AW-1:0]   r_ad;
    logic [NRD-1:0][XLEN-1:0] r_data;
    logic [NRD-1:0]           r_ack;
    logic [NRD-1:0]           r_rdy;
    logic                     iss_valid;
    logic [AW-1:0]            iss_ad;
    logic                     flush;

    register_file_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w_ad      (w_ad),
        .w_data    (w_data),
        .r_valid   (r_valid),
        .r_ad      (r_ad),
        .r_data    (r_data),
        .r_ack     (r_ack),
        .r_rdy     (r_rdy),
        .iss_valid (iss_valid),
        .iss_ad    (iss_ad),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    // Reference model state and the expected outputs after the coming edge.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    logic [XLEN-1:0] exp_data [NRD];
    bit              exp_rdy  [NRD];
    bit              exp_ack  [NRD];

    // Optional hand-computed expectations for the coming edge.
    bit              lit_d  [NRD];
    bit              lit_r  [NRD];
    bit              lit_a  [NRD];
    logic [XLEN-1:0] lit_dv [NRD];
    bit              lit_rv [NRD];
    bit              lit_av [NRD];
    string           lit_name;

    bit chk_en;
    int n_cmp;
    int n_fail;

    task automatic model_reset();
        for (int a = 0; a < NREGS; a++) begin
            m_regs[a] = '0;
            m_pend[a] = 1'b0;
        end
        for (int i = 0; i < NRD; i++) begin
            exp_data[i] = '0;
            exp_rdy[i]  = 1'b0;
            exp_ack[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        bit              mid [NREGS];
        int              a;
        logic [XLEN-1:0] v;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NREGS; k++) mid[k] = m_pend[k];
        for (int p = 0; p < NWR; p++) begin
            if (w_valid[p] && int'(w_ad[p]) < NREGS) mid[w_ad[p]] = 1'b0;
        end
        for (int i = 0; i < NRD; i++) begin
            if (r_valid[i]) begin
                a = int'(r_ad[i]);
                if (a >= NREGS || a == 0) begin
                    v = '0;
                end else begin
                    v = m_regs[a];
                    for (int p = 0; p < NWR; p++) begin
                        if (w_valid[p] && w_ad[p] == r_ad[i]) v = w_data[p];
                    end
                end
                exp_data[i] = v;
                exp_rdy[i]  = (a >= NREGS) ? 1'b1 : !mid[a];
                exp_ack[i]  = 1'b1;
            end else begin
                exp_ack[i] = 1'b0;
            end
        end
        for (int p = 0; p < NWR; p++) begin
            a = int'(w_ad[p]);
            if (w_valid[p] && a < NREGS && a != 0) m_regs[a] = w_data[p];
        end
        for (int k = 0; k < NREGS; k++) m_pend[k] = mid[k];
        if (iss_valid && iss_ad != '0 && int'(iss_ad) < NREGS) m_pend[iss_ad] = 1'b1;
        if (flush) begin
            for (int k = 0; k < NREGS; k++) m_pend[k] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NRD; i++) begin
                n_cmp++;
                if (r_ack[i] !== exp_ack[i]) begin
                    n_fail++;
                    $display("FAIL model_ack port%0d t=%0t: got %b expected %b", i, $time, r_ack[i], exp_ack[i]);
                end
                n_cmp++;
                if (r_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL model_data port%0d t=%0t: got %h expected %h", i, $time, r_data[i], exp_data[i]);
                end
                n_cmp++;
                if (r_rdy[i] !== exp_rdy[i]) begin
                    n_fail++;
                    $display("FAIL model_rdy port%0d t=%0t: got %b expected %b", i, $time, r_rdy[i], exp_rdy[i]);
                end
                if (lit_a[i]) begin
                    n_cmp++;
                    if (r_ack[i] !== lit_av[i]) begin
                        n_fail++;
                        $display("FAIL %s_ack port%0d: got %b expected %b", lit_name, i, r_ack[i], lit_av[i]);
                    end
                end
                if (lit_d[i]) begin
                    n_cmp++;
                    if (r_data[i] !== lit_dv[i]) begin
                        n_fail++;
                        $display("FAIL %s_data port%0d: got %h expected %h", lit_name, i, r_data[i], lit_dv[i]);
                    end
                end
                if (lit_r[i]) begin
                    n_cmp++;
                    if (r_rdy[i] !== lit_rv[i]) begin
                        n_fail++;
                        $display("FAIL %s_rdy port%0d: got %b expected %b", lit_name, i, r_rdy[i], lit_rv[i]);
                    end
                end
            end
        end
    end

    task automatic clear_in();
        w_valid   = '0;
        w_ad      = '0;
        w_data    = '0;
        r_valid   = '0;
        r_ad      = '0;
        iss_valid = 1'b0;
        iss_ad    = '0;
        flush     = 1'b0;
    endtask

    task automatic lit_off();
        for (int i = 0; i < NRD; i++) begin
            lit_d[i] = 1'b0;
            lit_r[i] = 1'b0;
            lit_a[i] = 1'b0;
        end
    endtask

    task automatic expect_lit(input string name, input int i,
                              input bit cd, input logic [XLEN-1:0] d,
                              input bit cr, input bit r,
                              input bit ca, input bit a);
        lit_name  = name;
        lit_d[i]  = cd;
        lit_dv[i] = d;
        lit_r[i]  = cr;
        lit_rv[i] = r;
        lit_a[i]  = ca;
        lit_av[i] = a;
    endtask

    task automatic wr(input int p, input reg_addr_t ad, input logic [XLEN-1:0] d);
        w_valid[p] = 1'b1;
        w_ad[p]    = ad;
        w_data[p]  = d;
    endtask

    task automatic rd(input int i, input reg_addr_t ad);
        r_valid[i] = 1'b1;
        r_ad[i]    = ad;
    endtask

    task automatic iss(input reg_addr_t ad);
        iss_valid = 1'b1;
        iss_ad    = ad;
    endtask

    // Inputs are set half a cycle ahead of the edge that consumes them.
    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
        clear_in();
        lit_off();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        rst    = 1'b0;
        clear_in();
        lit_off();
        model_reset();
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < NRD; i++) expect_lit("reset", i, 1'b1, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Write then read x5.
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        rd(0, 5'd5);
        expect_lit("rd_x5", 0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();

        // Colliding writes with bypassed read; port 1 wins.
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        rd(1, 5'd7);
        expect_lit("bypass_x7", 1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        rd(0, 5'd7);
        expect_lit("stored_x7", 0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // Register 0 ignores writes and issues.
        wr(0, 5'd0, 32'hFFFFFFFF);
        tick();
        rd(0, 5'd0);
        expect_lit("x0_data", 0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        iss(5'd0);
        tick();
        rd(0, 5'd0);
        expect_lit("x0_rdy", 0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Pending lifecycle of x3.
        iss(5'd3);
        tick();
        rd(0, 5'd3);
        expect_lit("x3_pend", 0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        wr(0, 5'd3, 32'h33);
        iss(5'd3);
        tick();
        rd(0, 5'd3);
        expect_lit("x3_reissue", 0, 1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        wr(1, 5'd3, 32'h34);
        tick();
        rd(0, 5'd3);
        expect_lit("x3_done", 0, 1'b1, 32'h34, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Flush clears all pending bits.
        iss(5'd4);
        tick();
        iss(5'd9);
        tick();
        rd(0, 5'd4);
        expect_lit("x4_prefl", 0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        rd(0, 5'd4);
        rd(1, 5'd9);
        expect_lit("flush", 0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_lit("flush", 1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a read.
        wr(0, 5'd2, 32'h55);
        tick();
        rd(0, 5'd2);
        rst = 1'b1;
        expect_lit("rst_mid", 0, 1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        expect_lit("rst_rel", 0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        rd(0, 5'd2);
        expect_lit("rst_after", 0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();

        // Randomized traffic; narrow address window forces collisions.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NWR; p++) begin
                w_valid[p] = 1'($urandom_range(0, 1));
                w_ad[p]    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS-1))
                                                         : AW'($urandom_range(0, 7));
                w_data[p]  = $urandom;
            end
            for (int i = 0; i < NRD; i++) begin
                r_valid[i] = 1'($urandom_range(0, 1));
                r_ad[i]    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS-1))
                                                         : AW'($urandom_range(0, 7));
            end
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_ad    = AW'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter XLEN, default 32: data word width in bits.
REQ-003 Parameter NREGS, default 32: architectural register count; AW = clog2(NREGS).
REQ-004 Parameter NRD, default 2: number of read ports.
REQ-005 Parameter NWR, default 2: number of write ports.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 w_valid  in  NWR  per-port write enable.
REQ-009 w_ad  in  NWR x AW  write address.
REQ-010 w_data  in  NWR x XLEN  write data.
REQ-011 r_valid  in  NRD  per-port read request.
REQ-012 r_ad  in  NRD x AW  read address.
REQ-013 r_data  out  NRD x XLEN  registered read data.
REQ-014 r_ack  out  NRD  high one cycle after an accepted r_valid.
REQ-015 r_rdy  out  NRD  registered: read register had no pending producer.
REQ-016 iss_valid  in  1  mark iss_ad as pending (instruction issued, result outstanding).
REQ-017 iss_ad  in  AW  destination register being issued.
REQ-018 flush  in  1  clear all pending bits.

Function
REQ-019 Register 0 SHALL read as zero, ignore writes, and never become pending.
REQ-020 Writes SHALL take effect on the rising clk edge; a write with w_ad >= NREGS SHALL be ignored.
REQ-021 Same-cycle writes to one address SHALL resolve so that the highest-indexed write port wins.
REQ-022 Reads SHALL have one-cycle latency: r_valid[i] at edge t gives r_data[i], r_rdy[i], and r_ack[i]=1 after edge t.
REQ-023 A read in cycle t of an address written in cycle t SHALL return the new write data (write-to-read bypass, same priority as REQ-021).
REQ-024 When r_valid[i]=0, r_data[i] and r_rdy[i] SHALL hold their previous values and r_ack[i] SHALL be 0.
REQ-025 Each register SHALL own one pending bit: set by iss_valid on iss_ad, cleared by any w_valid write to that address.
REQ-026 Simultaneous issue and write to the same address SHALL leave the bit pending (the new producer wins).
REQ-027 flush SHALL clear all pending bits and override a same-cycle issue; writes in the flush cycle still update data.
REQ-028 r_rdy[i] SHALL reflect the pending state after the same-cycle write clear but before the same-cycle issue set.
REQ-029 A read address >= NREGS SHALL return r_data=0 and r_rdy=1.

Reset
REQ-030 On rst, all registers, pending bits, r_data, r_rdy and r_ack SHALL go to 0 asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard in-flight reads, so r_ack=0 on the first edge after release.
REQ-032 The first accepted operations SHALL occur on the first rising edge with rst low.

Structure
REQ-033 XLEN/NREGS defaults, AW computation and the reg-address typedef SHALL live in the shared cpu_configuration package.
REQ-034 Pending-bit tracking SHALL be a separate sub-module, regfile_scoreboard, instantiated once.
REQ-035 Storage SHALL be flops (no latches, no negedge logic).

Verification
REQ-036 Write x5=0xDEADBEEF, then read port0 x5 -> r_data[0]=0xDEADBEEF, r_ack[0]=1, r_rdy[0]=1 one cycle later.
REQ-037 Port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle, while read port1 x7 -> r_data[1]=0x22, and a later read also returns 0x22.
REQ-038 Write x0=0xFFFFFFFF then read x0 -> r_data=0; iss_valid on x0 then read x0 -> r_rdy=1.
REQ-039 Issue x3 at t; read x3 at t+1 -> r_rdy=0; write x3 plus issue x3 at t+2, read at t+3 -> r_rdy=0; write x3 at t+4, read at t+5 -> r_rdy=1.
REQ-040 Issue x4, x9, then flush, then read x4 and x9 -> both r_rdy=1.
REQ-041 Write x2=0x55, read x2 with rst pulsed during the read cycle, then read x2 again -> r_ack=0 after release, then r_data=0.
